dm_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the single-port data memory between two requesters.
- m0 is the CPU MEM-stage load/store port; m1 is the debug/DMA port.
- Serialises accesses through a 3-state FSM and drives the memory's write-enable, address, write-data and write-PC inputs.
- Returns read data to each requester with a one-cycle ack.

---
 rtl/dm_arbiter_if.sv | 17 +
 rtl/dm_arbiter.sv | 98 +++++++++
 tb/tb_dm_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/dm_arbiter_if.sv
// Requester-side bus for one port of the data-memory arbiter (request fields in, ack/read data back).
// The requester holds req and its fields until ack; the arbiter latches the fields at grant.
interface dm_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [31:0]       pc;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, pc, input ack, rdata);
    modport slave  (input req, we, addr, wdata, pc, output ack, rdata);
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin two-port sequencer for the single-port data memory: IDLE -> ACCESS -> DONE, ack 2 cycles after grant.
// Requesters stall by holding req until their ack; DM_ARB_TRACE_EN adds a simulation-only access trace.
module dm_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    dm_arbiter_if.slave       m0,
    dm_arbiter_if.slave       m1,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wd,
    output logic [31:0]       dm_wpc,
    input  logic [DATA_W-1:0] dm_rd,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state;
    logic              rr_ptr;
    logic              gnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [31:0]       lat_pc;
    logic [DATA_W-1:0] rdata_q;
    logic              pick;
    logic              ack0;
    logic              ack1;

    // m1 wins when it is alone, or when both ask and the pointer favours it.
    always_comb begin
        pick = m1.req && (!m0.req || rr_ptr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            gnt       <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_pc    <= '0;
            rdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0.req || m1.req) begin
                        gnt       <= pick;
                        lat_we    <= pick ? m1.we    : m0.we;
                        lat_addr  <= pick ? m1.addr  : m0.addr;
                        lat_wdata <= pick ? m1.wdata : m0.wdata;
                        lat_pc    <= pick ? m1.pc    : m0.pc;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!lat_we) rdata_q <= dm_rd;
                    state <= DONE;
                end
                DONE: begin
                    rr_ptr <= ~gnt;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A reset cycle must never commit a write, even mid-access.
    assign dm_we    = (state == ACCESS) && lat_we && !reset;
    assign dm_addr  = lat_addr;
    assign dm_wd    = lat_wdata;
    assign dm_wpc   = lat_pc;
    assign busy     = (state != IDLE);

    assign ack0     = (state == DONE) && !gnt;
    assign ack1     = (state == DONE) && gnt;
    assign m0.ack   = ack0;
    assign m1.ack   = ack1;
    assign m0.rdata = ack0 ? rdata_q : '0;
    assign m1.rdata = ack1 ? rdata_q : '0;

`ifdef DM_ARB_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && state == ACCESS) begin
            if (lat_we)
                $display("m%0d @%h: *%h <= %h", gnt, lat_pc, lat_addr, lat_wdata);
            else
                $display("m%0d rd *%h", gnt, lat_addr);
        end
    end
`else
    // Trace disabled: no simulation-only logic.
`endif
endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a word-addressed memory model behind the dm_* port.
module tb_dm_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [31:0] dm_wpc;
    logic [31:0] dm_rd;
    logic        busy;
    logic [31:0] mem [256] = '{default: 32'h0};

    int nvec = 0;
    int nmis = 0;

    dm_arbiter_if m0_if ();
    dm_arbiter_if m1_if ();

    dm_arbiter dut (
        .clk    (clk),
        .reset  (reset),
        .m0     (m0_if.slave),
        .m1     (m1_if.slave),
        .dm_we  (dm_we),
        .dm_addr(dm_addr),
        .dm_wd  (dm_wd),
        .dm_wpc (dm_wpc),
        .dm_rd  (dm_rd),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    assign dm_rd = mem[dm_addr[9:2]];
    always @(posedge clk) if (dm_we) mem[dm_addr[9:2]] <= dm_wd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit m, input bit req, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] pc);
        if (m) begin
            m1_if.req = req; m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wdata; m1_if.pc = pc;
        end else begin
            m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wdata; m0_if.pc = pc;
        end
    endtask

    // Issue one access from IDLE, expect ack exactly two cycles later, then drop req.
    task automatic xfer(input bit m, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd, input string tag);
        int n = 0;
        drive(m, 1'b1, we, addr, wdata, 32'h100);
        @(negedge clk);
        while (!(m ? m1_if.ack : m0_if.ack) && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_lat"}, 64'(n), 64'd2);
        chk({tag, "_oack"}, 64'(m ? m0_if.ack : m1_if.ack), 64'd0);
        chk({tag, "_ordata"}, 64'(m ? m0_if.rdata : m1_if.rdata), 64'd0);
        if (!we) chk({tag, "_rd"}, 64'(m ? m1_if.rdata : m0_if.rdata), 64'(exp_rd));
        tick();
        drive(m, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_we",    64'(dm_we), 64'd0);
        chk("rst_addr",  64'(dm_addr), 64'd0);
        chk("rst_wd",    64'(dm_wd), 64'd0);
        chk("rst_wpc",   64'(dm_wpc), 64'd0);
        chk("rst_ack0",  64'(m0_if.ack), 64'd0);
        chk("rst_ack1",  64'(m1_if.ack), 64'd0);
        chk("rst_rd0",   64'(m0_if.rdata), 64'd0);
        chk("rst_rd1",   64'(m1_if.rdata), 64'd0);

        // m0 write 0x10 <= DEADBEEF, pc 0x3000
        tick();
        drive(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 32'h3000);
        @(negedge clk);
        chk("w_c0_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("w_c1_we",   64'(dm_we), 64'd1);
        chk("w_c1_addr", 64'(dm_addr), 64'h10);
        chk("w_c1_wd",   64'(dm_wd), 64'hDEADBEEF);
        chk("w_c1_wpc",  64'(dm_wpc), 64'h3000);
        chk("w_c1_busy", 64'(busy), 64'd1);
        chk("w_c1_ack",  64'(m0_if.ack), 64'd0);
        @(negedge clk);
        chk("w_c2_ack0", 64'(m0_if.ack), 64'd1);
        chk("w_c2_ack1", 64'(m1_if.ack), 64'd0);
        chk("w_c2_we",   64'(dm_we), 64'd0);
        chk("w_c2_hold", 64'(dm_addr), 64'h10);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        xfer(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, "m1_rd10");

        // Both requesting from reset: acks m0@2, m1@5, m0@8, m1@11
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("rr_c%0d_ack0", c), 64'(m0_if.ack), 64'((c == 2) || (c == 8)));
            chk($sformatf("rr_c%0d_ack1", c), 64'(m1_if.ack), 64'((c == 5) || (c == 11)));
            if (c == 2) chk("rr_rd0", 64'(m0_if.rdata), 64'hDEADBEEF);
        end
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);

        // m1 alone, back to back, after its own grant
        xfer(1'b1, 1'b1, 32'h40, 32'h1234, 32'h0, "m1_w40");
        xfer(1'b1, 1'b0, 32'h40, 32'h0, 32'h1234, "m1_r40a");
        xfer(1'b1, 1'b0, 32'h40, 32'h0, 32'h1234, "m1_r40b");

        // Reset during ACCESS of an m1 write
        drive(1'b1, 1'b1, 1'b1, 32'h20, 32'h55, 32'h200);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("rsta_we",   64'(dm_we), 64'd0);
        chk("rsta_busy", 64'(busy), 64'd1);
        tick();
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rsta_ack1_%0d", c), 64'(m1_if.ack), 64'd0);
            chk($sformatf("rsta_busy_%0d", c), 64'(busy), 64'd0);
        end
        tick();
        xfer(1'b1, 1'b0, 32'h20, 32'h0, 32'h0, "m1_r20");

        // Field changes during ACCESS are ignored
        xfer(1'b0, 1'b1, 32'h4, 32'hA5A50004, 32'h0, "m0_w4");
        xfer(1'b0, 1'b1, 32'h8, 32'h00000808, 32'h0, "m0_w8");
        drive(1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 32'h0);
        tick();
        m0_if.addr = 32'h8;
        m0_if.we   = 1'b1;
        @(negedge clk);
        chk("chg_addr", 64'(dm_addr), 64'h4);
        chk("chg_we",   64'(dm_we), 64'd0);
        @(negedge clk);
        chk("chg_ack",  64'(m0_if.ack), 64'd1);
        chk("chg_rd",   64'(m0_if.rdata), 64'hA5A50004);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        xfer(1'b1, 1'b0, 32'h8, 32'h0, 32'h00000808, "m1_r8");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
